// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode map, FSM state encoding and status-flag payload
// for the registered ALU (alu_pipe) and its iterative multiplier.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b0110;
  localparam logic [3:0] OP_SLTS  = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic branch_taken;
  } flags_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: iterative shift-add unsigned multiplier, one multiplier bit per
// cycle. A start pulse loads the operands; WIDTH cycles later done_c is high for
// one cycle while prod_c presents the full 2*WIDTH-bit product (combinational,
// captured by the parent on that edge).
// Ports: clk, rst_n (async active-low), start, a, b -> done_c, prod_c.
module alu_pipe_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done_c,
  output logic [2*WIDTH-1:0] prod_c
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One partial product per cycle while the counter is non-zero.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = PW'(a);
      mplier_d = b;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Last iteration: the accumulator's next value is the final product.
  assign done_c = (cnt_q == CNT_W'(1));
  assign prod_c = acc_d;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshake on both sides.
// Single-cycle ops produce a result the cycle after accept; accept and output
// transfer may coincide for 1 op/cycle throughput. Optional multi-cycle MUL is
// built only when ALU_PIPE_MUL_EN is defined (otherwise opcode 1000 is a NOP).
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, opcode, shamt,
// dir (input side); out_valid/out_ready, result, zero, carry, ovf,
// branch_taken (output side, all registered).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         opcode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               carry,
  output logic               ovf,
  output logic               branch_taken
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic             idle_c;
  logic             in_fire_c;
  logic [WIDTH-1:0] res_c;
  flags_t           flg_c;
  logic [WIDTH:0]   sum_c, diff_c, shl_c, shr_c;

`ifdef ALU_PIPE_MUL_EN
  state_e             state_q, state_d;
  logic               mul_start_c;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start_c),
    .a      (a),
    .b      (b),
    .done_c (mul_done_c),
    .prod_c (mul_prod_c)
  );

  assign idle_c = (state_q == ST_IDLE);
`else
  assign idle_c = 1'b1;
`endif

  assign in_ready  = rst_n && idle_c && (!out_valid_q || out_ready);
  assign in_fire_c = in_valid && in_ready;

  // Single-cycle datapath. Shifts use one extra bit so the last bit shifted
  // out lands in a fixed position (0 when shamt is 0 or beyond the operand).
  always_comb begin
    sum_c  = {1'b0, a} + {1'b0, b};
    diff_c = {1'b0, a} - {1'b0, b};
    shl_c  = {1'b0, a} << shamt;
    shr_c  = {a, 1'b0} >> shamt;
    res_c  = '0;
    flg_c  = '0;
    case (opcode)
      OP_ADD, OP_ADDI: begin
        res_c     = sum_c[WIDTH-1:0];
        flg_c.carry = sum_c[WIDTH];
        flg_c.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_BEQ, OP_BNE: begin
        res_c       = diff_c[WIDTH-1:0];
        flg_c.carry = diff_c[WIDTH];
        flg_c.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
        if (opcode == OP_BEQ) flg_c.branch_taken = (a == b);
        if (opcode == OP_BNE) flg_c.branch_taken = (a != b);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SLT:  res_c = WIDTH'(a < b);
      OP_SLTS: res_c = WIDTH'($signed(a) < $signed(b));
      OP_SHIFT: begin
        if (dir) begin
          res_c       = shr_c[WIDTH:1];
          flg_c.carry = shr_c[0];
        end else begin
          res_c       = shl_c[WIDTH-1:0];
          flg_c.carry = shl_c[WIDTH];
        end
      end
      default: res_c = '0;
    endcase
    flg_c.zero = (res_c == '0);
  end

  // Handshake / FSM next state. Output registers change only on accept or
  // multiply completion, both of which imply the old result has drained.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
`ifdef ALU_PIPE_MUL_EN
    state_d     = state_q;
    mul_start_c = 1'b0;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    if (state_q == ST_MUL) begin
      if (mul_done_c) begin
        state_d       = ST_IDLE;
        out_valid_d   = 1'b1;
        result_d      = mul_prod_c[WIDTH-1:0];
        flags_d       = '0;
        flags_d.zero  = (mul_prod_c[WIDTH-1:0] == '0);
        flags_d.carry = |mul_prod_c[2*WIDTH-1:WIDTH];
      end
    end else if (in_fire_c && (opcode == OP_MUL)) begin
      state_d     = ST_MUL;
      mul_start_c = 1'b1;
    end else
`endif
    if (in_fire_c) begin
      out_valid_d = 1'b1;
      result_d    = res_c;
      flags_d     = flg_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= ST_IDLE;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= state_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign zero         = flags_q.zero;
  assign carry        = flags_q.carry;
  assign ovf          = flags_q.ovf;
  assign branch_taken = flags_q.branch_taken;

endmodule
